// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the host-side instruction loader.
// Instruction is 80 bits: lower word [31:0], middle word [63:32], upper halfword [79:64].
package instr_loader_pkg;

    typedef logic [31:0] word_type;
    typedef logic [15:0] halfword_type;
    typedef logic [79:0] instr_type;

    localparam int INSTR_BEATS = 3;
    localparam logic [2:0] INSTR_WE_ALL  = 3'b111;
    localparam logic [2:0] INSTR_WE_NONE = 3'b000;

    typedef enum logic [1:0] {
        BEAT0 = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2,
        PUSH  = 2'd3
    } loader_state_type;

    // True when a third beat carries bits that the upper halfword cannot hold.
    function automatic logic upper_overflow(input word_type beat);
        return (beat[31:16] != 16'h0000);
    endfunction

endpackage

// File: rtl/instr_loader.sv
// Assembles three 32-bit host beats into one 80-bit instruction and writes it atomically to the
// instruction FIFO. Optional macro INSTR_LOADER_UPPER_CHECK_EN adds a sticky error on a dirty third beat.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int BEATS_PER_INSTR = 3,
    parameter int COUNT_WIDTH     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  word_type               s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output word_type               lower_instr_word,
    output word_type               middle_instr_word,
    output halfword_type           upper_instr_word,
    output logic [2:0]             instr_write_enable,
    input  logic                   instr_fifo_full,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] instr_count,
    output logic                   error
);

    generate
        if (BEATS_PER_INSTR != INSTR_BEATS) begin : g_bad_beats
            $error("instr_loader: BEATS_PER_INSTR must be 3");
        end
    endgenerate

    loader_state_type       state_r;
    loader_state_type       state_next_s;
    word_type               lower_r;
    word_type               middle_r;
    halfword_type           upper_r;
    logic [COUNT_WIDTH-1:0] count_r;
    logic                   ready_s;
    logic                   busy_s;
    logic [2:0]             we_s;
    logic                   handshake_s;
    logic                   push_s;

    assign handshake_s = s_valid && ready_s;
    assign push_s      = (we_s == INSTR_WE_ALL);

    // State register; reset drops any partially assembled instruction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= BEAT0;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state: advance on each beat handshake, leave PUSH only when the FIFO has room.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            BEAT0:   if (handshake_s) state_next_s = BEAT1; else state_next_s = BEAT0;
            BEAT1:   if (handshake_s) state_next_s = BEAT2; else state_next_s = BEAT1;
            BEAT2:   if (handshake_s) state_next_s = PUSH;  else state_next_s = BEAT2;
            PUSH:    if (!instr_fifo_full) state_next_s = BEAT0; else state_next_s = PUSH;
            default: state_next_s = BEAT0;
        endcase
    end

    // Outputs: gating with rst keeps ready and the write strobe low in the reset cycle.
    always_comb begin
        ready_s = 1'b0;
        busy_s  = 1'b0;
        we_s    = INSTR_WE_NONE;
        case (state_r)
            BEAT0: begin
                ready_s = rst;
            end
            BEAT1, BEAT2: begin
                ready_s = rst;
                busy_s  = 1'b1;
            end
            PUSH: begin
                busy_s = 1'b1;
                if (rst && !instr_fifo_full) begin
                    we_s = INSTR_WE_ALL;
                end else begin
                    we_s = INSTR_WE_NONE;
                end
            end
            default: begin
                ready_s = 1'b0;
                busy_s  = 1'b0;
                we_s    = INSTR_WE_NONE;
            end
        endcase
    end

    // Word registers load only on their own beat handshake, so they hold steady through PUSH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lower_r  <= 32'h0000_0000;
            middle_r <= 32'h0000_0000;
            upper_r  <= 16'h0000;
        end else if (handshake_s) begin
            case (state_r)
                BEAT0:   lower_r  <= s_data;
                BEAT1:   middle_r <= s_data;
                BEAT2:   upper_r  <= s_data[15:0];
                default: lower_r  <= lower_r;
            endcase
        end
    end

    // Issued-instruction counter, free-running modulo 2^COUNT_WIDTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= {COUNT_WIDTH{1'b0}};
        end else if (push_s) begin
            count_r <= count_r + COUNT_WIDTH'(1);
        end
    end

`ifdef INSTR_LOADER_UPPER_CHECK_EN
    logic error_r;

    // Sticky flag for a third beat whose upper half would be silently truncated.
    always_ff @(posedge clk) begin
        if (!rst) begin
            error_r <= 1'b0;
        end else if (handshake_s && (state_r == BEAT2) && upper_overflow(s_data)) begin
            error_r <= 1'b1;
        end
    end

    assign error = error_r;
`else
    logic unused_upper_s;
    assign unused_upper_s = ^s_data[31:16];
    assign error          = 1'b0;
`endif

    assign s_ready            = ready_s;
    assign busy               = busy_s;
    assign instr_write_enable = we_s;
    assign lower_instr_word   = lower_r;
    assign middle_instr_word  = middle_r;
    assign upper_instr_word   = upper_r;
    assign instr_count        = count_r;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed scenarios plus randomized host/FIFO traffic
// checked each cycle against a beat-list reference model.
module tb_instr_loader;
    import instr_loader_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    word_type     s_data;
    logic         s_valid;
    logic         s_ready;
    word_type     lower_instr_word;
    word_type     middle_instr_word;
    halfword_type upper_instr_word;
    logic [2:0]   instr_write_enable;
    logic         instr_fifo_full;
    logic         busy;
    logic [31:0]  instr_count;
    logic         error;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    instr_loader #(.BEATS_PER_INSTR(3), .COUNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .lower_instr_word(lower_instr_word), .middle_instr_word(middle_instr_word),
        .upper_instr_word(upper_instr_word), .instr_write_enable(instr_write_enable),
        .instr_fifo_full(instr_fifo_full), .busy(busy), .instr_count(instr_count), .error(error)
    );

    always #5 clk = ~clk;

    // Reference model: beats collected so far, whether a full instruction awaits the FIFO,
    // the last value written to each instruction word, the issue count and the error flag.
    word_type   m_beats[$];
    bit         m_pending;
    word_type   m_lo, m_mid;
    logic [15:0] m_up;
    logic [31:0] m_count;
    bit         m_err;
    logic [2:0] last_we;
    bit         last_hs;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_beats.delete();
        m_pending = 0;
        m_lo = '0; m_mid = '0; m_up = '0;
        m_count = '0;
        m_err = 0;
    endtask

    // One clock: apply inputs, compare all outputs with the model, then advance the model.
    task automatic step(input logic v, input word_type d, input logic f, input logic r);
        bit exp_ready;
        bit exp_write;
        @(negedge clk);
        s_valid = v; s_data = d; instr_fifo_full = f; rst = r;
        #1;
        exp_ready = r && !m_pending;
        exp_write = r && m_pending && !f;
        check_val("s_ready", {31'd0, s_ready}, {31'd0, exp_ready});
        check_val("write_enable", {29'd0, instr_write_enable}, exp_write ? 32'd7 : 32'd0);
        check_val("busy", {31'd0, busy}, {31'd0, (m_pending || m_beats.size() != 0)});
        check_val("lower", lower_instr_word, m_lo);
        check_val("middle", middle_instr_word, m_mid);
        check_val("upper", {16'd0, upper_instr_word}, {16'd0, m_up});
        check_val("count", instr_count, m_count);
        check_val("error", {31'd0, error}, {31'd0, m_err});
        last_we = instr_write_enable;
        last_hs = v && exp_ready;
        @(posedge clk);
        if (!r) begin
            model_reset();
        end else if (m_pending) begin
            if (!f) begin
                m_pending = 0;
                m_count++;
            end
        end else if (v) begin
            case (m_beats.size())
                0: m_lo = d;
                1: m_mid = d;
                default: begin
                    m_up = d[15:0];
`ifdef INSTR_LOADER_UPPER_CHECK_EN
                    if (d[31:16] != 16'd0) m_err = 1;
`endif
                end
            endcase
            m_beats.push_back(d);
            if (m_beats.size() == 3) begin
                m_beats.delete();
                m_pending = 1;
            end
        end
    endtask

    word_type hd;
    bit       hv;
    int       writes;

    initial begin
        model_reset();
        s_valid = 1'b0; s_data = '0; instr_fifo_full = 1'b0; rst = 1'b0;
        step(1'b1, 32'h5555_5555, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // Basic instruction, then explicit checks of the pushed words.
        step(1'b1, 32'h1111_1111, 1'b0, 1'b1);
        step(1'b1, 32'h2222_2222, 1'b0, 1'b1);
        step(1'b1, 32'h0000_ABCD, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check_val("t1_we", {29'd0, last_we}, 32'd7);
        check_val("t1_lower", lower_instr_word, 32'h1111_1111);
        check_val("t1_middle", middle_instr_word, 32'h2222_2222);
        check_val("t1_upper", {16'd0, upper_instr_word}, 32'h0000_ABCD);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check_val("t1_count", instr_count, 32'd1);
        check_val("t1_busy", {31'd0, busy}, 32'd0);

        // FIFO full for five cycles: no strobe, no ready; a single write when it drops.
        step(1'b1, 32'hA0A0_0001, 1'b1, 1'b1);
        step(1'b1, 32'hA0A0_0002, 1'b1, 1'b1);
        step(1'b1, 32'h0000_0003, 1'b1, 1'b1);
        writes = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
            if (last_we != 3'b000 || s_ready) writes++;
        end
        check_val("t2_held", writes, 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check_val("t2_we", {29'd0, last_we}, 32'd7);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check_val("t2_count", instr_count, 32'd2);

        // Toggling valid: only handshake cycles latch data.
        step(1'b1, 32'h3333_0001, 1'b0, 1'b1);
        step(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        step(1'b1, 32'h3333_0002, 1'b0, 1'b1);
        step(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0003, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check_val("t3_we", {29'd0, last_we}, 32'd7);
        check_val("t3_lower", lower_instr_word, 32'h3333_0001);
        check_val("t3_middle", middle_instr_word, 32'h3333_0002);

        // Reset mid-instruction discards the partial beats.
        step(1'b1, 32'h4444_0001, 1'b0, 1'b1);
        step(1'b1, 32'h4444_0002, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h5555_0001, 1'b0, 1'b1);
        step(1'b1, 32'h5555_0002, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0005, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check_val("t4_lower", lower_instr_word, 32'h5555_0001);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check_val("t4_count", instr_count, 32'd1);

        // Back-to-back with valid held high: a write every fourth cycle.
        writes = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 32'h0000_1000 + i, 1'b0, 1'b1);
            check_val("t5_slot", {29'd0, last_we}, (i % 4 == 3) ? 32'd7 : 32'd0);
            if (last_we == 3'b111) writes++;
        end
        check_val("t5_writes", writes, 32'd4);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check_val("t5_count", instr_count, 32'd5);

        // Dirty upper half on the third beat.
        step(1'b1, 32'h7777_7777, 1'b0, 1'b1);
        step(1'b1, 32'h8888_8888, 1'b0, 1'b1);
        step(1'b1, 32'h0001_FFFF, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check_val("t6_upper", {16'd0, upper_instr_word}, 32'h0000_FFFF);
        step(1'b0, 32'h0, 1'b0, 1'b1);
`ifdef INSTR_LOADER_UPPER_CHECK_EN
        check_val("t6_error", {31'd0, error}, 32'd1);
`else
        check_val("t6_error", {31'd0, error}, 32'd0);
`endif

        // Randomized traffic; the host holds data/valid until a handshake.
        hv = 0; hd = '0;
        for (int i = 0; i < 2000; i++) begin
            if (!hv) begin
                hv = ($urandom_range(0, 3) != 0);
                hd = $urandom();
                if ($urandom_range(0, 3) != 0) hd[31:16] = 16'd0;
            end
            step(hv, hd, ($urandom_range(0, 9) < 3), ($urandom_range(0, 99) != 0));
            if (last_hs) hv = 0;
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
